quadenc_delta: RTL



---
 rtl/quadenc_pkg.sv | 22 ++
 rtl/quadenc_step_detect.sv | 48 ++++
 rtl/quadenc_delta.sv | 123 ++++++++++++
 3 files changed

// File: rtl/quadenc_pkg.sv
// Shared quadrature encoder definitions: position count, step codes and
// accumulator saturation limits.
package quadenc_pkg;

   localparam int POSITIONS_DEF = 24;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_UP,
      STEP_DOWN,
      STEP_ERR
   } step_t;

   function automatic int sat_hi(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_lo(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/quadenc_step_detect.sv
// Classifies each change of the wrapping position count as a single step,
// no step, or an illegal jump.
module quadenc_step_detect
   import quadenc_pkg::*;
#(
   parameter int POSITIONS = POSITIONS_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] pos_in,
   output step_t      step
);

   localparam logic [5:0] PMAX = 6'(POSITIONS - 1);

   logic [5:0] pos_last;
   logic       primed;
   logic [5:0] up_pos;
   logic [5:0] dn_pos;

   always_comb begin
      up_pos = (pos_last == PMAX) ? 6'd0 : pos_last + 6'd1;
      dn_pos = (pos_last == 6'd0) ? PMAX : pos_last - 6'd1;
      step   = STEP_NONE;
      if (!primed || pos_in == pos_last)
         step = STEP_NONE;
      // an out-of-range pos_last (after resync) has no legal neighbours
      else if (pos_in > PMAX || pos_last > PMAX)
         step = STEP_ERR;
      else if (pos_in == up_pos)
         step = STEP_UP;
      else if (pos_in == dn_pos)
         step = STEP_DOWN;
      else
         step = STEP_ERR;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pos_last <= '0;
         primed   <= 1'b0;
      end else begin
         pos_last <= pos_in;
         primed   <= 1'b1;
      end
   end

endmodule

// File: rtl/quadenc_delta.sv
// Signed step accumulator with read-and-clear snapshot and level irq.
// Optional idle "rotation stopped" irq term: define QUADENC_DELTA_IDLE_EN.
module quadenc_delta
   import quadenc_pkg::*;
#(
   parameter int POSITIONS   = POSITIONS_DEF,
   parameter int DELTA_W     = 8,
   parameter int IRQ_THRESH  = 1,
   parameter int IDLE_CYCLES = 50000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [5:0]                pos_in,
   input  logic                      rd_req,
   output logic                      rd_ack,
   output logic signed [DELTA_W-1:0] delta_out,
   output logic                      err_out,
   output logic                      sat_out,
   output logic                      irq
);

   localparam logic signed [DELTA_W-1:0] ACC_MAX = DELTA_W'(sat_hi(DELTA_W));
   localparam logic signed [DELTA_W-1:0] ACC_MIN = DELTA_W'(sat_lo(DELTA_W));
   localparam logic signed [DELTA_W:0]   THR     = (DELTA_W+1)'(IRQ_THRESH);

   step_t                      step;
   logic signed [DELTA_W-1:0]  acc;
   logic signed [DELTA_W-1:0]  acc_step;
   logic signed [DELTA_W-1:0]  acc_new;
   logic signed [DELTA_W:0]    acc_ext;
   logic                       err;
   logic                       sat;
   logic                       err_cyc;
   logic                       sat_cyc;
   logic                       err_new;
   logic                       sat_new;
   logic                       sat_hit;
   logic                       mag_hit;
   logic                       idle_hit;

   quadenc_step_detect #(
      .POSITIONS(POSITIONS)
   ) u_step (
      .clk   (clk),
      .rst_n (rst_n),
      .pos_in(pos_in),
      .step  (step)
   );

   always_comb begin
      acc_step = acc;
      sat_hit  = 1'b0;
      unique case (step)
         STEP_UP: begin
            if (acc == ACC_MAX) sat_hit = 1'b1;
            else acc_step = acc + DELTA_W'(1);
         end
         STEP_DOWN: begin
            if (acc == ACC_MIN) sat_hit = 1'b1;
            else acc_step = acc - DELTA_W'(1);
         end
         default: ;
      endcase
      err_cyc = err | (step == STEP_ERR);
      sat_cyc = sat | sat_hit;
      // a read snapshots this cycle's events, so the live state restarts at 0
      acc_new = rd_req ? '0 : acc_step;
      err_new = err_cyc & ~rd_req;
      sat_new = sat_cyc & ~rd_req;
      acc_ext = {acc_new[DELTA_W-1], acc_new};
      mag_hit = (acc_ext >= THR) || (acc_ext <= -THR);
   end

`ifdef QUADENC_DELTA_IDLE_EN
   localparam int IW = $clog2(IDLE_CYCLES + 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

   logic [IW-1:0] idle;
   logic [IW-1:0] idle_new;

   always_comb begin
      if (rd_req || step == STEP_UP || step == STEP_DOWN)
         idle_new = '0;
      else if (idle == IDLE_MAX)
         idle_new = idle;
      else
         idle_new = idle + IW'(1);
      idle_hit = (acc_new != '0) && (idle_new == IDLE_MAX);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) idle <= '0;
      else idle <= idle_new;
   end
`else
   assign idle_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc       <= '0;
         err       <= 1'b0;
         sat       <= 1'b0;
         rd_ack    <= 1'b0;
         delta_out <= '0;
         err_out   <= 1'b0;
         sat_out   <= 1'b0;
         irq       <= 1'b0;
      end else begin
         acc    <= acc_new;
         err    <= err_new;
         sat    <= sat_new;
         rd_ack <= rd_req;
         irq    <= mag_hit | err_new | sat_new | idle_hit;
         if (rd_req) begin
            delta_out <= acc_step;
            err_out   <= err_cyc;
            sat_out   <= sat_cyc;
         end
      end
   end

endmodule
